// File: rtl/vpm_pkg.sv
// Shared helpers for the VPM pipeline sink: counter/pointer widths and
// parameter legality tests used at elaboration time.
package vpm_pkg;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return int'($clog2(depth + 1));
  endfunction

  // Pointer width: indexes 0..depth-1, wraps naturally for power-of-two depth.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : int'($clog2(depth));
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage : vpm_pkg

// File: rtl/vpm_sink_fifo.sv
// Storage FIFO for the pipeline sink.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         synchronous clear; drops same-cycle write/read
//   wr_en/wr_data qualified write (caller guarantees room or concurrent read)
//   rd_en         qualified pop of the head entry
//   rd_data       head entry (combinational read of the registered array)
//   count         registered occupancy
//   count_next_c  occupancy after this edge (combinational)
//   full, empty   occupancy flags derived from count
module vpm_sink_fifo
  import vpm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        rd_en,
  output logic [DATA_WIDTH-1:0]       rd_data,
  output logic [cnt_w(DEPTH)-1:0]     count,
  output logic [cnt_w(DEPTH)-1:0]     count_next_c,
  output logic                        full,
  output logic                        empty
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned PW = ptr_w(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Next occupancy; clear wins over any same-cycle traffic.
  always_comb begin
    count_next_c = count;
    if (clear) begin
      count_next_c = '0;
    end else begin
      count_next_c = count + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_next_c;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PW'(1);
        if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en && !clear) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule : vpm_sink_fifo

// File: rtl/vpm_pipe_sink.sv
// Output stage of a VPM pipeline: buffers last-stage items, presents them
// downstream with valid/ready, and raises an early stall so items already
// in flight always have room.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   icontrol, idata    item valid / payload from pipeline stage O
//   flush              synchronous clear of FIFO contents
//   out_valid/out_data head entry towards downstream
//   out_ready          downstream accepts the head entry
//   stall_req          registered request to hold the pipeline
//   count              current occupancy
//   overflow           sticky: an item was dropped while full
module vpm_pipe_sink
  import vpm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned INFLIGHT   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    icontrol,
  input  logic [DATA_WIDTH-1:0]   idata,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  input  logic                    out_ready,
  output logic                    stall_req,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    overflow
);

  localparam int unsigned CW = cnt_w(DEPTH);

  // Elaboration-time parameter legality.
  if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("vpm_pipe_sink: DEPTH must be a power of two >= 2");
  end
  if (INFLIGHT < 1 || INFLIGHT >= DEPTH) begin : g_bad_inflight
    $error("vpm_pipe_sink: INFLIGHT must satisfy 1 <= INFLIGHT < DEPTH");
  end

  logic          full;
  logic          empty;
  logic          rd_c;
  logic          wr_c;
  logic          drop_c;
  logic [CW-1:0] count_next_c;
  logic [CW-1:0] free_next_c;

  // A full FIFO still accepts a write when the head leaves the same cycle.
  assign rd_c        = out_valid & out_ready & ~flush;
  assign wr_c        = icontrol & (~full | rd_c) & ~flush;
  assign drop_c      = icontrol & full & ~(out_valid & out_ready) & ~flush;
  assign out_valid   = ~empty;
  assign free_next_c = CW'(DEPTH) - count_next_c;

  vpm_sink_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .clear        (flush),
    .wr_en        (wr_c),
    .wr_data      (idata),
    .rd_en        (rd_c),
    .rd_data      (out_data),
    .count        (count),
    .count_next_c (count_next_c),
    .full         (full),
    .empty        (empty)
  );

  // Stall watermark; on flush count_next is 0 so this reduces to DEPTH <= INFLIGHT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_req <= 1'b0;
    end else begin
      stall_req <= (free_next_c <= CW'(INFLIGHT));
    end
  end

  // Sticky overflow; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop_c) begin
      overflow <= 1'b1;
    end
  end

endmodule : vpm_pipe_sink
